regfile_op_sequencer: RTL and testbench
=======================================

// Module: regfile_op_sequencer
// PURPOSE
//  Command-driven master for the 8x4 dual-port register file: accepts register operations over a
//  valid/ready interface and drives the file's write port and both read-address ports.
//  Executes READ, MOVE, ADD and SWAP, then returns one response per command.
//  Sits between a host/controller and the register file; the file's read ports are asynchronous.
// PARAMETERS
//  DATA_W  4  register width in bits; must match the register file
//  ADDR_W  3  register address width (2**ADDR_W registers)
// PORTS
//  clk           in   1       single clock; all state updates on posedge
//  rst           in   1       asynchronous, active-high reset
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       sequencer can accept a command
//  cmd_op        in   2       00 READ, 01 MOVE, 10 ADD, 11 SWAP
//  cmd_dst       in   ADDR_W  destination register (MOVE/ADD)
//  cmd_src_a     in   ADDR_W  source A (all ops)
//  cmd_src_b     in   ADDR_W  source B (ADD, SWAP)
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       host accepts response
//  rsp_data      out  DATA_W  value read (READ) or value of first write (others)
//  rsp_carry     out  1       ADD carry-out; 0 for other ops
//  rf_wr_en      out  1       register file write enable
//  rf_wr_addr    out  ADDR_W  register file write address
//  rf_wr_data    out  DATA_W  register file write data
//  rf_rd_addr_a  out  ADDR_W  register file read address A
//  rf_rd_addr_b  out  ADDR_W  register file read address B
//  rf_rd_data_a  in   DATA_W  register file read data A (combinational from rf_rd_addr_a)
//  rf_rd_data_b  in   DATA_W  register file read data B (combinational from rf_rd_addr_b)
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, rf_wr_en=0,
//    rf_wr_addr/rf_wr_data/rf_rd_addr_a/rf_rd_addr_b=0. Reset mid-op aborts; no further writes.
//  - FSM: IDLE -> EXEC -> [SWAP2] -> RESP -> IDLE. cmd_ready=1 only in IDLE.
//  - IDLE: on cmd_valid&&cmd_ready, latch op/dst/src_a/src_b and go to EXEC.
//  - EXEC (1 cycle): rf_rd_addr_a=src_a and rf_rd_addr_b=src_b, both driven from latched regs.
//    READ: no write; rsp_data<=rd_data_a.
//    MOVE: write dst<=rd_data_a; rsp_data<=rd_data_a.
//    ADD: {carry,sum}=rd_data_a+rd_data_b (DATA_W+1 bits); write dst<=sum;
//      rsp_data<=sum, rsp_carry<=carry.
//    SWAP: write src_a<=rd_data_b; temp<=rd_data_a; rsp_data<=rd_data_b; go to SWAP2.
//  - SWAP2 (1 cycle): write src_b<=temp.
//  - rf_wr_en is a 1-cycle pulse per write, combinational from state; never asserted in IDLE/RESP.
//  - RESP: rsp_valid=1; rsp_data/rsp_carry stable until rsp_valid&&rsp_ready, then IDLE.
//  - Latency (accept at edge T): EXEC in cycle T+1, rsp_valid from T+2 (SWAP: T+3).
//    Throughput: 1 cmd per 3 cycles (SWAP 4) with rsp_ready held high.
//  - Operands are sampled in the same cycle as the write, so the old value is used.
//    ADD/MOVE with dst==src therefore use the pre-write value.
//  - SWAP with src_a==src_b: two writes of the same value; register unchanged.
//  - ADD wraps mod 2**DATA_W; overflow is reported only via rsp_carry.
//  - cmd_* inputs are ignored outside IDLE; rsp_ready is ignored when rsp_valid=0.
// STRUCTURE
//  - Shared package regfile_pkg: opcode localparams (OP_READ/OP_MOVE/OP_ADD/OP_SWAP),
//    FSM state encoding, DATA_W/ADDR_W defaults.
//  - Single module, no sub-module. The adder is inline; the FSM and datapath are in one file.
// TESTING (bench instantiates dual_port_register_file_8x4 as the target)
//  - Reset: rst=1 mid-SWAP (in SWAP2) -> rf_wr_en=0 immediately, cmd_ready=1, rsp_valid=0 after release.
//  - MOVE: r2=4'h9 preloaded; MOVE dst=5 src_a=2 -> r5=4'h9, rsp_data=4'h9, rsp_valid at T+2.
//  - ADD overflow: r1=4'hC, r3=4'h7; ADD dst=1 a=1 b=3 -> r1=4'h3, rsp_carry=1.
//    Checks dst==src reads the old value.
//  - SWAP: r0=4'hA, r7=4'h5 -> r0=4'h5, r7=4'hA; two rf_wr_en pulses; rsp_valid at T+3.
//    Repeat with a=b=4 -> r4 unchanged.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0.
//    Back-to-back cmd_valid held -> next command accepted the cycle after the handshake.
//  - READ: r6=4'hE, READ a=6 -> rsp_data=4'hE, rf_wr_en never asserted.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file operation sequencer: opcodes, FSM states, widths.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned ADDR_W_DEF = 3;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StSwap2,
        StResp
    } state_t;

endpackage

// File: rtl/dual_port_register_file_8x4.sv
// Register file with one synchronous write port and two asynchronous read ports.
module dual_port_register_file_8x4 #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command-driven master for the dual-port register file: runs READ/MOVE/ADD/SWAP and
// returns one response per command over a valid/ready pair.
module regfile_op_sequencer
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b
);

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [DATA_W-1:0] temp_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_carry_q;

    // One extra bit so the carry-out falls out of the same addition.
    logic [DATA_W:0]   add_full;

    assign add_full = {1'b0, rf_rd_data_a} + {1'b0, rf_rd_data_b};

    assign cmd_ready    = (state == StIdle);
    assign rsp_valid    = (state == StResp);
    assign rsp_data     = rsp_data_q;
    assign rsp_carry    = rsp_carry_q;
    assign rf_rd_addr_a = src_a_q;
    assign rf_rd_addr_b = src_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            op_q        <= OP_READ;
            dst_q       <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            temp_q      <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        dst_q   <= cmd_dst;
                        src_a_q <= cmd_src_a;
                        src_b_q <= cmd_src_b;
                        state   <= StExec;
                    end
                end
                StExec: begin
                    rsp_carry_q <= 1'b0;
                    state       <= StResp;
                    case (op_q)
                        OP_ADD: begin
                            rsp_data_q  <= add_full[DATA_W-1:0];
                            rsp_carry_q <= add_full[DATA_W];
                        end
                        OP_SWAP: begin
                            // src_a takes B now; the old A is held for the second write.
                            temp_q     <= rf_rd_data_a;
                            rsp_data_q <= rf_rd_data_b;
                            state      <= StSwap2;
                        end
                        default: begin
                            rsp_data_q <= rf_rd_data_a;
                        end
                    endcase
                end
                StSwap2: begin
                    state <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = dst_q;
        rf_wr_data = '0;
        case (state)
            StExec: begin
                rf_wr_en = (op_q != OP_READ);
                case (op_q)
                    OP_ADD: begin
                        rf_wr_data = add_full[DATA_W-1:0];
                    end
                    OP_SWAP: begin
                        rf_wr_addr = src_a_q;
                        rf_wr_data = rf_rd_data_b;
                    end
                    default: begin
                        rf_wr_data = rf_rd_data_a;
                    end
                endcase
            end
            StSwap2: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = src_b_q;
                rf_wr_data = temp_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer driving a real register file, checked against a
// transaction-level model of register contents and expected writes/responses.
module tb_regfile_op_sequencer;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_dst = 3'd0;
    logic [2:0] cmd_src_a = 3'd0;
    logic [2:0] cmd_src_b = 3'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rf_wr_en;
    logic [2:0] rf_wr_addr;
    logic [3:0] rf_wr_data;
    logic [2:0] rf_rd_addr_a;
    logic [2:0] rf_rd_addr_b;
    logic [3:0] rf_rd_data_a;
    logic [3:0] rf_rd_data_b;

    logic       pre_en = 1'b0;
    logic [2:0] pre_addr = 3'd0;
    logic [3:0] pre_data = 4'd0;
    logic       m_wr_en;
    logic [2:0] m_wr_addr;
    logic [3:0] m_wr_data;

    assign m_wr_en   = pre_en | rf_wr_en;
    assign m_wr_addr = pre_en ? pre_addr : rf_wr_addr;
    assign m_wr_data = pre_en ? pre_data : rf_wr_data;

    always #5 clk = ~clk;

    regfile_op_sequencer #(.DATA_W(4), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dst      (cmd_dst),
        .cmd_src_a    (cmd_src_a),
        .cmd_src_b    (cmd_src_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_carry    (rsp_carry),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b)
    );

    dual_port_register_file_8x4 #(.DATA_W(4), .ADDR_W(3)) u_rf (
        .clk       (clk),
        .wr_en     (m_wr_en),
        .wr_addr   (m_wr_addr),
        .wr_data   (m_wr_data),
        .rd_addr_a (rf_rd_addr_a),
        .rd_addr_b (rf_rd_addr_b),
        .rd_data_a (rf_rd_data_a),
        .rd_data_b (rf_rd_data_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register contents, outstanding writes and the pending response.
    typedef struct packed {
        logic [2:0] addr;
        logic [3:0] data;
    } wr_t;

    logic [3:0] model_rf [8];
    wr_t        exp_wr_q [$];
    bit         pending = 1'b0;
    int         acc_cyc = 0;
    int         exp_lat = 2;
    logic [3:0] exp_data = 4'd0;
    logic       exp_carry = 1'b0;
    int         wr_cnt = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t        w;
        logic [3:0] a;
        logic [3:0] b;
        int         s;
        if (rst) begin
            check("rst_wr_en", rf_wr_en, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            exp_wr_q.delete();
            pending = 1'b0;
        end else begin
            check("cmd_ready", cmd_ready, !pending);
            if (rf_wr_en) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", rf_wr_en, 0);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr", rf_wr_addr, w.addr);
                    check("wr_data", rf_wr_data, w.data);
                    model_rf[w.addr] = w.data;
                end
            end
            check("rsp_valid", rsp_valid, pending && ((cyc - acc_cyc) >= exp_lat));
            if (rsp_valid && pending) begin
                check("rsp_data", rsp_data, exp_data);
                check("rsp_carry", rsp_carry, exp_carry);
                if (rsp_ready) begin
                    check("wr_outstanding", exp_wr_q.size(), 0);
                    pending = 1'b0;
                end
            end
            if (cmd_valid && cmd_ready) begin
                a = model_rf[cmd_src_a];
                b = model_rf[cmd_src_b];
                exp_carry = 1'b0;
                exp_lat = 2;
                case (cmd_op)
                    OP_READ: exp_data = a;
                    OP_MOVE: begin
                        exp_data = a;
                        w.addr = cmd_dst; w.data = a; exp_wr_q.push_back(w);
                    end
                    OP_ADD: begin
                        s = int'(a) + int'(b);
                        exp_data = 4'(s % 16);
                        exp_carry = (s >= 16);
                        w.addr = cmd_dst; w.data = exp_data; exp_wr_q.push_back(w);
                    end
                    default: begin
                        exp_data = b;
                        exp_lat = 3;
                        w.addr = cmd_src_a; w.data = b; exp_wr_q.push_back(w);
                        w.addr = cmd_src_b; w.data = a; exp_wr_q.push_back(w);
                    end
                endcase
                pending = 1'b1;
                acc_cyc = cyc;
            end
        end
    end

    logic [3:0] got_data;
    logic       got_carry;
    int         got_lat;
    int         got_hold;

    task automatic preload(input logic [2:0] addr, input logic [3:0] data);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        model_rf[addr] = data;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // mode 0: rsp_ready high; 1: stall five valid cycles; 2: random rsp_ready.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] a,
                           input logic [2:0] b, input int mode);
        int acc;
        int first;
        int vcnt;
        bit done;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b;
        done = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom_range(0, 3));
        cmd_dst = 3'($urandom_range(0, 7));
        cmd_src_a = 3'($urandom_range(0, 7));
        cmd_src_b = 3'($urandom_range(0, 7));
        done = 1'b0; vcnt = 0; first = -1;
        for (int t = 0; t < 100; t++) begin
            rsp_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (vcnt >= 5) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rsp_valid) begin
                if (first < 0) first = cyc;
                vcnt++;
                if (rsp_ready) begin
                    got_data = rsp_data;
                    got_carry = rsp_carry;
                    done = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        got_lat = first - acc;
        got_hold = vcnt;
        if (!done) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int s0;
        int n;
        int last;
        bit found;

        repeat (2) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_carry", rsp_carry, 0);
        check("reset_wr_en", rf_wr_en, 0);
        check("reset_wr_addr", rf_wr_addr, 0);
        check("reset_wr_data", rf_wr_data, 0);
        check("reset_rd_addr_a", rf_rd_addr_a, 0);
        check("reset_rd_addr_b", rf_rd_addr_b, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) preload(3'(i), 4'($urandom_range(0, 15)));

        preload(3'd2, 4'h9);
        run_cmd(OP_MOVE, 3'd5, 3'd2, 3'd0, 0);
        check("move_rsp", got_data, 4'h9);
        check("move_lat", got_lat, 2);
        run_cmd(OP_READ, 3'd0, 3'd5, 3'd0, 0);
        check("move_r5", got_data, 4'h9);

        preload(3'd1, 4'hC);
        preload(3'd3, 4'h7);
        run_cmd(OP_ADD, 3'd1, 3'd1, 3'd3, 0);
        check("add_sum", got_data, 4'h3);
        check("add_carry", got_carry, 1);
        run_cmd(OP_READ, 3'd0, 3'd1, 3'd0, 0);
        check("add_r1", got_data, 4'h3);

        preload(3'd0, 4'hA);
        preload(3'd7, 4'h5);
        w0 = wr_cnt;
        run_cmd(OP_SWAP, 3'd0, 3'd0, 3'd7, 0);
        check("swap_rsp", got_data, 4'h5);
        check("swap_lat", got_lat, 3);
        check("swap_pulses", wr_cnt - w0, 2);
        run_cmd(OP_READ, 3'd0, 3'd0, 3'd0, 0);
        check("swap_r0", got_data, 4'h5);
        run_cmd(OP_READ, 3'd0, 3'd7, 3'd0, 0);
        check("swap_r7", got_data, 4'hA);

        preload(3'd4, 4'h6);
        run_cmd(OP_SWAP, 3'd0, 3'd4, 3'd4, 0);
        check("swap_same_rsp", got_data, 4'h6);
        run_cmd(OP_READ, 3'd0, 3'd4, 3'd0, 0);
        check("swap_same_r4", got_data, 4'h6);

        preload(3'd6, 4'hE);
        w0 = wr_cnt;
        run_cmd(OP_READ, 3'd0, 3'd6, 3'd0, 0);
        check("read_rsp", got_data, 4'hE);
        check("read_carry", got_carry, 0);
        check("read_no_write", wr_cnt - w0, 0);

        // r1=3, r3=7 from the ADD above.
        run_cmd(OP_ADD, 3'd2, 3'd1, 3'd3, 1);
        check("bp_rsp", got_data, 4'hA);
        check("bp_carry", got_carry, 0);
        check("bp_hold", got_hold, 6);

        @(posedge clk); #1;
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = OP_READ; cmd_src_a = 3'd6;
        found = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b_first", found, 1);
        s0 = cyc; n = 0; last = s0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
            if (cmd_ready) begin
                n++;
                last = cyc;
            end
        end
        check("b2b_accepts", n, 3);
        check("b2b_last", last - s0, 9);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end

        for (int i = 0; i < 150; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 2);
        end

        preload(3'd2, 4'h3);
        preload(3'd3, 4'hC);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_src_a = 3'd2; cmd_src_b = 3'd3; rsp_ready = 1'b1;
        @(negedge clk);
        check("rstt_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rstt_swap2_wr", rf_wr_en, 1);
        check("rstt_swap2_addr", rf_wr_addr, 3);
        rst = 1'b1;
        #1;
        check("rstt_wr_en", rf_wr_en, 0);
        check("rstt_cmd_ready", cmd_ready, 1);
        check("rstt_rsp_valid", rsp_valid, 0);
        check("rstt_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_cmd(OP_READ, 3'd0, 3'd2, 3'd0, 0);
        check("rstt_r2", got_data, 4'hC);
        run_cmd(OP_READ, 3'd0, 3'd3, 3'd0, 0);
        check("rstt_r3", got_data, 4'hC);

        for (int i = 0; i < 8; i++) run_cmd(OP_READ, 3'd0, 3'(i), 3'd0, 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
